// File: rtl/mem_if_pkg.sv
// Shared definitions for the RAM access path: default widths, FSM state encoding, op encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_if_pkg;

  localparam int DEF_ADDR_WIDTH = 9;   // 512-word RAM
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles the control-unit request/response signals and the RAM port signals.
// Latency: n/a (wiring only).
// Backpressure: busy from the slave side; requests while busy are dropped, not queued.
//   slave  : the access unit (takes req/we/addr/wdata/mem_rdata, drives the rest)
//   master : control unit plus RAM model, mirror image of slave
interface mem_access_unit_if
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  // control unit side
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mar_q;

  // RAM side
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output busy, done, rdata, mar_q, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  busy, done, rdata, mar_q, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_unit_mdr.sv
// Memory data register: loads write data on request accept or RAM read data in CAPTURE.
// Latency: one clock from load strobe to q.
// Backpressure: none; holds its value whenever neither load strobe is set.
//   ports: clock, clear (async active-low), load_wdata/wdata, load_rdata/mem_rdata, q
module mdr_reg
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  load_wdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  load_rdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] q
);

  // The two loads are mutually exclusive by construction (IDLE vs CAPTURE),
  // the priority here only keeps the mux a simple chain.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)          q <= '0;
    else if (load_wdata) q <= wdata;
    else if (load_rdata) q <= mem_rdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the synchronous RAM: owns MAR/MDR and sequences single-word reads and writes.
// Latency: done in the cycle after accept+1 edges (write) or accept+2 edges (read).
// Backpressure: busy high outside IDLE; req is only sampled in IDLE, never queued.
//   ports: clock, clear (async active-low), bus (slave modport: control unit + RAM port)
module mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  mem_access_unit_if.slave   bus
);

  state_t                state_q, state_d;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic                  accept;
  logic                  capture;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Strobes are pure decodes of state_q, so an asynchronous clear removes
  // them in the same cycle and an ISSUE interrupted before its edge writes nothing.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.req) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_write = (op_q == OP_WRITE);
        bus.mem_read  = (op_q == OP_READ);
        state_d       = (op_q == OP_WRITE) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        // RAM registered its read data on the ISSUE edge; grab it now.
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar  <= '0;
      op_q <= OP_READ;
    end else if (accept) begin
      mar  <= bus.addr;
      op_q <= bus.we;
    end
  end

  // On a read accept the MDR keeps its old value until CAPTURE.
  mdr_reg #(.DATA_WIDTH(DATA_WIDTH)) u_mdr (
    .clock      (clock),
    .clear      (clear),
    .load_wdata (accept && (bus.we == OP_WRITE)),
    .wdata      (bus.wdata),
    .load_rdata (capture),
    .mem_rdata  (bus.mem_rdata),
    .q          (mdr)
  );

  assign bus.rdata     = mdr;
  assign bus.mem_wdata = mdr;
  assign bus.mem_addr  = mar;
  assign bus.mar_q     = mar;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic preload;

  always #5 clock = ~clock;

  mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // RAM: writes on the strobed edge, read data registered one edge after the address.
  logic [DW-1:0] ram [0:511];
  always @(posedge clock) begin
    if (preload) begin
      ram[9'h095] <= 32'h000000FF;
      ram[9'h010] <= 32'hA5A5A5A5;
      ram[9'h1FF] <= 32'h11111111;
      ram[9'h020] <= 32'hCAFEF00D;
    end else begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata    <= ram[bus.mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Full read from IDLE; returns rdata sampled during the done cycle.
  task automatic do_read(input logic [AW-1:0] a, input string tag, output logic [DW-1:0] r);
    issue(1'b0, a, '0);
    tick();                 // ISSUE
    bus.req = 1'b0;
    tick();                 // CAPTURE
    tick();                 // DONE
    check({tag, "_done"}, bus.done, 1'b1);
    r = bus.rdata;
    tick();                 // back in IDLE
  endtask

  logic [DW-1:0] rd;
  int nr, nw, nd, both, first_d, last_d;

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    preload   = 1'b1;
    clear     = 1'b0;

    // ---- reset state
    repeat (2) tick();
    check("rst_busy",  bus.busy,      1'b0);
    check("rst_done",  bus.done,      1'b0);
    check("rst_rd",    bus.mem_read,  1'b0);
    check("rst_wr",    bus.mem_write, 1'b0);
    check("rst_mar",   bus.mar_q,     9'h000);
    check("rst_rdata", bus.rdata,     32'h0);
    check("rst_maddr", bus.mem_addr,  9'h000);
    preload = 1'b0;
    clear   = 1'b1;
    tick();
    check("rel_busy", bus.busy, 1'b0);

    // ---- req together with clear: request dropped
    clear = 1'b0;
    issue(1'b1, 9'h095, 32'h0BADF00D);
    tick();
    bus.req = 1'b0;
    #1 clear = 1'b1;
    tick();
    check("reqclr_busy", bus.busy,  1'b0);
    check("reqclr_mar",  bus.mar_q, 9'h000);

    // ---- read 0x095
    issue(1'b0, 9'h095, 32'h0);
    tick();
    bus.req = 1'b0;
    check("rd_iss_rd",   bus.mem_read,  1'b1);
    check("rd_iss_wr",   bus.mem_write, 1'b0);
    check("rd_iss_addr", bus.mem_addr,  9'h095);
    check("rd_iss_busy", bus.busy,      1'b1);
    check("rd_iss_done", bus.done,      1'b0);
    tick();
    check("rd_cap_rd",   bus.mem_read,  1'b0);
    check("rd_cap_done", bus.done,      1'b0);
    check("rd_cap_addr", bus.mem_addr,  9'h095);
    tick();
    check("rd_done",     bus.done,      1'b1);
    check("rd_rdata",    bus.rdata,     32'h000000FF);
    tick();
    check("rd_idle_done", bus.done, 1'b0);
    check("rd_idle_busy", bus.busy, 1'b0);

    // ---- write 0xDEADBEEF to 0x1FF (top address), then read back
    issue(1'b1, 9'h1FF, 32'hDEADBEEF);
    tick();
    bus.req = 1'b0;
    check("wr_iss_wr",    bus.mem_write, 1'b1);
    check("wr_iss_rd",    bus.mem_read,  1'b0);
    check("wr_iss_addr",  bus.mem_addr,  9'h1FF);
    check("wr_iss_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("wr_iss_done",  bus.done,      1'b0);
    tick();
    check("wr_done",      bus.done,      1'b1);
    check("wr_done_wr",   bus.mem_write, 1'b0);
    check("wr_ram",       ram[9'h1FF],   32'hDEADBEEF);
    tick();
    check("wr_idle_busy", bus.busy, 1'b0);
    do_read(9'h1FF, "rb", rd);
    check("rb_rdata", rd, 32'hDEADBEEF);

    // ---- request while busy is ignored
    nd = 0;
    issue(1'b0, 9'h095, 32'h0);
    tick();                                   // ISSUE
    issue(1'b1, 9'h010, 32'h12345678);
    tick();                                   // CAPTURE
    check("bz_cap_mar", bus.mar_q, 9'h095);
    tick();                                   // DONE
    bus.req = 1'b0;
    if (bus.done) nd++;
    check("bz_rdata", bus.rdata, 32'h000000FF);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) nd++;
    end
    check("bz_ndone", nd, 1);
    check("bz_ram",   ram[9'h010], 32'hA5A5A5A5);
    check("bz_busy",  bus.busy, 1'b0);

    // ---- clear during ISSUE of a write
    issue(1'b1, 9'h020, 32'hBADBAD00);
    tick();
    bus.req = 1'b0;
    check("rw_iss_wr", bus.mem_write, 1'b1);
    #2 clear = 1'b0;
    #1;
    check("rw_wr_drop", bus.mem_write, 1'b0);
    check("rw_busy",    bus.busy,      1'b0);
    check("rw_mar",     bus.mar_q,     9'h000);
    check("rw_rdata",   bus.rdata,     32'h0);
    nd = 0;
    tick();
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) nd++;
    end
    check("rw_ndone", nd, 0);
    check("rw_ram",   ram[9'h020], 32'hCAFEF00D);
    do_read(9'h020, "rw_rb", rd);
    check("rw_rb_rdata", rd, 32'hCAFEF00D);

    // ---- req held high: reads every 4 cycles
    nr = 0; nw = 0; nd = 0; both = 0; first_d = -1; last_d = -1;
    issue(1'b0, 9'h095, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.mem_read)  nr++;
      if (bus.mem_write) nw++;
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.done) begin
        nd++;
        if (first_d < 0) first_d = i;
        last_d = i;
        check("held_rdata", bus.rdata, 32'h000000FF);
      end
    end
    bus.req = 1'b0;
    check("held_nread",  nr,      4);
    check("held_nwrite", nw,      0);
    check("held_both",   both,    0);
    check("held_ndone",  nd,      4);
    check("held_first",  first_d, 3);
    check("held_last",   last_d,  15);
    repeat (5) tick();
    check("held_end_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
